// File: rtl/gates_sweep_ctrl.sv
// Self-check sequencer for Multiple_Gates: sweeps entrada 0..3, waits SETTLE_CYCLES, checks gate outputs against a golden model.
// Each code takes SETTLE_CYCLES+2 cycles; done pulses one cycle after the last check, all outputs registered.
module gates_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic [1:0] entrada,
  input  logic [6:0] gates_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_mask,
  output logic [3:0] err_vec,
  output logic [2:0] fail_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  state_t     state_q;
  logic [1:0] entrada_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [6:0] err_mask_q;
  logic [3:0] err_vec_q;
  logic [2:0] fail_count_q;

  logic       a;
  logic       b;
  logic [6:0] expected;
  logic [6:0] mismatch;
  logic       miss_any;
  logic [2:0] fail_count_d;

  // The driven code doubles as the sweep index, so the golden model follows it directly.
  assign a            = entrada_q[0];
  assign b            = entrada_q[1];
  assign expected     = {~(a ^ b), a ^ b, ~(a & b), ~(a | b), a & b, a | b, ~a};
  assign mismatch     = gates_in ^ expected;
  assign miss_any     = |mismatch;
  assign fail_count_d = fail_count_q + {2'b00, miss_any};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      entrada_q    <= 2'd0;
      cnt_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_mask_q   <= 7'd0;
      err_vec_q    <= 4'd0;
      fail_count_q <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q      <= SETTLE;
            entrada_q    <= 2'd0;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b1;
            pass_q       <= 1'b0;
            err_mask_q   <= 7'd0;
            err_vec_q    <= 4'd0;
            fail_count_q <= 3'd0;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q   <= IDLE;
            entrada_q <= 2'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        CHECK: begin
          // Abort takes precedence over recording this code's sample.
          if (abort) begin
            state_q   <= IDLE;
            entrada_q <= 2'd0;
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            pass_q    <= 1'b0;
          end else begin
            err_mask_q <= err_mask_q | mismatch;
            if (miss_any) begin
              err_vec_q[entrada_q] <= 1'b1;
              fail_count_q         <= fail_count_d;
            end
            if (entrada_q != 2'd3) begin
              state_q   <= SETTLE;
              entrada_q <= entrada_q + 2'd1;
              cnt_q     <= 4'd0;
            end else begin
              state_q <= FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (fail_count_d == 3'd0);
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign entrada    = entrada_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_mask   = err_mask_q;
  assign err_vec    = err_vec_q;
  assign fail_count = fail_count_q;

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Bench for gates_sweep_ctrl: a behavioural gate block with fault injection feeds the DUT; a scoreboard
// holds the expected per-cycle trace and per-sweep results. A second instance runs with SETTLE_CYCLES=0.
module tb_gates_sweep_ctrl;

  localparam int P = 3;  // phase length for SETTLE_CYCLES=1

  localparam logic [6:0] GOLDEN [0:3] = '{7'b1011001, 7'b0110010, 7'b0110011, 7'b1000110};

  typedef struct {
    int         cyc;
    logic       busy;
    logic       done;
    logic [1:0] ent;
  } tr_t;

  typedef struct {
    logic       pass;
    logic [6:0] mask;
    logic [3:0] vec;
    logic [2:0] fc;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] entrada;
  logic [6:0] gates_in;
  logic       busy, done, pass;
  logic [6:0] err_mask;
  logic [3:0] err_vec;
  logic [2:0] fail_count;

  logic       start0 = 1'b0;
  logic       abort0 = 1'b0;
  logic [1:0] entrada0;
  logic [6:0] gates0;
  logic       busy0, done0, pass0;
  logic [6:0] mask0;
  logic [3:0] vec0;
  logic [2:0] fc0;

  int fault_mode = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  tr_t  trace_q[$];
  res_t res_q[$];

  function automatic logic [6:0] gate_fn(input logic [1:0] e, input int mode);
    logic       a, b;
    logic [6:0] g;
    a = e[0];
    b = e[1];
    g = {~(a ^ b), a ^ b, ~(a & b), ~(a | b), a & b, a | b, ~a};
    if (mode == 1) g[3] = 1'b0;
    else if (mode == 2) g = 7'd0;
    return g;
  endfunction

  assign gates_in = gate_fn(entrada, fault_mode);
  assign gates0   = gate_fn(entrada0, 0);

  gates_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .entrada(entrada), .gates_in(gates_in),
    .busy(busy), .done(done), .pass(pass), .err_mask(err_mask), .err_vec(err_vec), .fail_count(fail_count)
  );

  gates_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .entrada(entrada0), .gates_in(gates0),
    .busy(busy0), .done(done0), .pass(pass0), .err_mask(mask0), .err_vec(vec0), .fail_count(fc0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic res_t model_sweep(input int mode);
    res_t       r;
    logic [6:0] mm;
    logic [1:0] e;
    r.mask = 7'd0;
    r.vec  = 4'd0;
    r.fc   = 3'd0;
    for (int k = 0; k < 4; k++) begin
      e  = 2'(k);
      mm = gate_fn(e, mode) ^ GOLDEN[k];
      r.mask |= mm;
      if (mm != 7'd0) begin
        r.vec[k] = 1'b1;
        r.fc     = r.fc + 3'd1;
      end
    end
    r.pass = (r.fc == 3'd0);
    return r;
  endfunction

  task automatic push_exp(input int c, input logic b, input logic d, input logic [1:0] e);
    tr_t t;
    t.cyc  = c;
    t.busy = b;
    t.done = d;
    t.ent  = e;
    trace_q.push_back(t);
  endtask

  // Expected trace for a sweep whose start is sampled at the end of cycle c, first nmax cycles.
  task automatic push_sweep(input int c, input int nmax);
    for (int k = 1; k <= nmax; k++) begin
      if (k <= 4 * P) push_exp(c + k, 1'b1, 1'b0, 2'((k - 1) / P));
      else if (k == 4 * P + 1) push_exp(c + k, 1'b0, 1'b1, 2'd3);
      else push_exp(c + k, 1'b0, 1'b0, 2'd3);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_results(input string tag, input logic [6:0] m, input logic [3:0] v,
                             input logic [2:0] f, input logic p);
    chk_eq({tag, "_mask"}, 32'(err_mask), 32'(m));
    chk_eq({tag, "_vec"}, 32'(err_vec), 32'(v));
    chk_eq({tag, "_fc"}, 32'(fail_count), 32'(f));
    chk_eq({tag, "_pass"}, 32'(pass), 32'(p));
  endtask

  task automatic run_sweep(input int mode, input bit poke, input string tag, input logic [6:0] m,
                           input logic [3:0] v, input logic [2:0] f, input logic p);
    int c;
    fault_mode = mode;
    c = cyc;
    start = 1'b1;
    push_sweep(c, 4 * P + 2);
    res_q.push_back(model_sweep(mode));
    tick(1);
    start = 1'b0;
    if (poke) begin
      tick(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(4 * P - 3);
    end else begin
      tick(4 * P + 1);
    end
    chk_results(tag, m, v, f, p);
    tick(2);
    chk_results({tag, "_held"}, m, v, f, p);
  endtask

  // Trace and scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    tr_t  t;
    res_t r;
    while (trace_q.size() > 0 && trace_q[0].cyc < cyc) begin
      t = trace_q.pop_front();
      chk_eq("trace_stale", 32'(t.cyc), 32'(cyc));
    end
    if (trace_q.size() > 0 && trace_q[0].cyc == cyc) begin
      t = trace_q.pop_front();
      chk_eq("trace_busy", 32'(busy), 32'(t.busy));
      chk_eq("trace_done", 32'(done), 32'(t.done));
      chk_eq("trace_entrada", 32'(entrada), 32'(t.ent));
    end
    if (done) begin
      if (res_q.size() == 0) begin
        chk_eq("spurious_done", 32'(done), 32'd0);
      end else begin
        r = res_q.pop_front();
        chk_eq("sb_pass", 32'(pass), 32'(r.pass));
        chk_eq("sb_mask", 32'(err_mask), 32'(r.mask));
        chk_eq("sb_vec", 32'(err_vec), 32'(r.vec));
        chk_eq("sb_fc", 32'(fail_count), 32'(r.fc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int m;
    tick(3);
    chk_results("reset", 7'd0, 4'd0, 3'd0, 1'b0);
    chk_eq("reset_busy", 32'(busy), 32'd0);
    chk_eq("reset_done", 32'(done), 32'd0);
    chk_eq("reset_entrada", 32'(entrada), 32'd0);
    rst = 1'b0;
    tick(2);

    run_sweep(0, 1'b1, "clean", 7'd0, 4'd0, 3'd0, 1'b1);
    run_sweep(1, 1'b0, "nor_sa0", 7'b0001000, 4'b0001, 3'd1, 1'b0);
    run_sweep(2, 1'b0, "all_zero", 7'b1111111, 4'b1111, 3'd4, 1'b0);

    // Abort during code 1 settle keeps code 0's partial result; then abort-in-idle cases.
    fault_mode = 2;
    c = cyc;
    start = 1'b1;
    push_sweep(c, 5);
    for (int k = 6; k <= 9; k++) push_exp(c + k, 1'b0, 1'b0, 2'd0);
    tick(1);
    start = 1'b0;
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk_results("abort", 7'b1011001, 4'b0001, 3'd1, 1'b0);
    tick(1);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    abort = 1'b0;
    chk_results("abort_idle", 7'b1011001, 4'b0001, 3'd1, 1'b0);
    run_sweep(0, 1'b0, "post_abort", 7'd0, 4'd0, 3'd0, 1'b1);

    // Reset during the first CHECK with start held high, then a normal sweep.
    fault_mode = 2;
    c = cyc;
    start = 1'b1;
    push_sweep(c, 3);
    tick(3);
    rst = 1'b1;
    push_exp(c + 4, 1'b0, 1'b0, 2'd0);
    tick(1);
    rst = 1'b0;
    chk_results("rst_mid", 7'd0, 4'd0, 3'd0, 1'b0);
    push_sweep(c + 4, 4 * P + 2);
    res_q.push_back(model_sweep(2));
    tick(1);
    start = 1'b0;
    tick(4 * P + 1);
    chk_results("after_rst", 7'b1111111, 4'b1111, 3'd4, 1'b0);

    // SETTLE_CYCLES=0 instance with start held: 8 busy cycles, FINISH, one IDLE, repeat.
    start0 = 1'b1;
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      m = k % 10;
      chk_eq("sw0_done", 32'(done0), 32'(m == 9));
      chk_eq("sw0_busy", 32'(busy0), 32'(m >= 1 && m <= 8));
      if (m >= 1 && m <= 8) chk_eq("sw0_entrada", 32'(entrada0), 32'((m - 1) / 2));
      else chk_eq("sw0_entrada_idle", 32'(entrada0), (k == 0) ? 32'd0 : 32'd3);
      if (m == 9) begin
        chk_eq("sw0_pass", 32'(pass0), 32'd1);
        chk_eq("sw0_fc", 32'(fc0), 32'd0);
      end
    end
    start0 = 1'b0;
    tick(2);

    chk_eq("trace_left", 32'(trace_q.size()), 32'd0);
    chk_eq("results_left", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gates_sweep_ctrl.md
Name: gates_sweep_ctrl

Overview:
Self-check sequencer for the Multiple_Gates block. On a start request it drives all four codes of the 2-bit `entrada` bus onto the gate block in order 0,1,2,3. It waits a programmable settle time per code, then samples the seven gate outputs and compares them against an internal golden model. It reports pass/fail, a per-gate error mask and a per-code error vector. It sits beside Multiple_Gates in the top and replaces the bench-driven input sweep with in-design, cycle-accurate sequencing.

Parameters:
SETTLE_CYCLES, 1, idle cycles between applying a code and sampling outputs (legal 0..15).

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous, active-high reset.
start  in  1  level-sampled request to begin a sweep; honoured only in IDLE.
abort  in  1  terminates a running sweep; no done pulse.
entrada  out  2  code driven to Multiple_Gates; A = entrada[0], B = entrada[1].
gates_in  in  7  sampled gate outputs; bit order [6:0] = {XNOR, XOR, NAND, NOR, AND, OR, NOT_A}.
busy  out  1  high while a sweep is in progress.
done  out  1  one-cycle pulse when a sweep completes normally.
pass  out  1  1 when the last completed sweep had no mismatch; valid when done has fired and no start has followed.
err_mask  out  7  OR of the mismatch bits over all codes, same bit order as gates_in.
err_vec  out  4  bit k set when code k had any mismatch.
fail_count  out  3  number of codes with a mismatch (0..4).

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous, active-high, and has priority over everything.
- Reset values: state = IDLE, entrada = 0, busy = 0, done = 0, pass = 0, err_mask = 0, err_vec = 0, fail_count = 0.
- Golden model, evaluated on the currently driven `entrada`:
  - NOT_A = ~A
  - OR = A|B, AND = A&B, NOR = ~(A|B), NAND = ~(A&B)
  - XOR = A^B, XNOR = ~(A^B)
  - mismatch = gates_in ^ expected.
- FSM states: IDLE, SETTLE, CHECK, FINISH.
  - IDLE: entrada holds its last value (0 after reset).
    - If start=1 and abort=0: next cycle entrada = 0, idx = 0, settle counter = 0, busy = 1.
    - Also on this transition: err_mask, err_vec, fail_count and pass are cleared; go to SETTLE.
  - SETTLE: count cycles; when the counter reaches SETTLE_CYCLES, go to CHECK. With SETTLE_CYCLES = 0, SETTLE lasts exactly one cycle.
  - CHECK: one cycle.
    - Sample gates_in at the end of the cycle.
    - OR mismatch into err_mask; set err_vec[idx] if mismatch != 0; increment fail_count in that case.
    - If idx < 3: idx++, entrada = idx+1, counter = 0, go to SETTLE.
    - Else go to FINISH.
  - FINISH: done = 1 for exactly this cycle, busy = 0, pass = (fail_count == 0), then return to IDLE.
- Timing:
  - Each code phase lasts SETTLE_CYCLES+2 cycles.
  - With start sampled at edge 0: busy is high for cycles 1..4*(SETTLE_CYCLES+2), and done is high in cycle 4*(SETTLE_CYCLES+2)+1.
  - Default parameter: done in cycle 13.
- start while busy: ignored, no restart.
- start held high through FINISH: a new sweep begins on the cycle after FINISH (back-to-back sweeps allowed).
- abort while busy:
  - Next cycle returns to IDLE with busy = 0, done = 0, pass = 0 and entrada = 0.
  - Partial err_mask, err_vec and fail_count are kept for debug.
- abort and start together in IDLE: abort wins and no sweep starts.
- abort in IDLE alone: no effect.
- rst mid-sweep: immediate return to the reset values; no done pulse.
- Results (pass, err_mask, err_vec, fail_count) are held stable between done and the next accepted start.

Test Plan:
- Correct gate model connected, SETTLE_CYCLES=1, start pulsed at cycle 0 -> entrada sequence 0,1,2,3 each held 3 cycles; done pulses at cycle 13; pass=1, err_mask=0, err_vec=0, fail_count=0.
- Fault injection, gates_in[3] (NOR) stuck at 0 -> NOR mismatches only at code 0; err_mask=7'b0001000, err_vec=4'b0001, fail_count=1, pass=0.
- gates_in forced to 7'h00 -> err_vec=4'b1111, fail_count=4, err_mask=7'b1111111, pass=0.
- abort asserted at cycle 5 of a sweep -> busy=0 at cycle 6, no done pulse, entrada=0; a following start runs a full clean sweep and ends with pass=1.
- rst asserted mid-CHECK with start held high -> all outputs equal the reset values on the next cycle; after rst drops, a sweep starts and completes normally.
- start held high continuously, SETTLE_CYCLES=0 -> done pulses every 10 cycles (FINISH, then a new sweep); start pulses during busy do not perturb the entrada sequence.
